// File: rtl/sdp_ram_rd_arbiter.sv
// sdp_ram_rd_arbiter
//   Round-robin arbiter that shares the read port of a simple dual-port RAM
//   between two requesters. The RAM is assumed to run in output-registered
//   mode (2-cycle read latency). The write client drives port A directly and
//   is always accepted.
//
// Configuration macro:
//   SDP_ARB_WR_FWD_EN - when defined, a write to the read address in the
//                       acceptance cycle or the following cycle is forwarded
//                       into the response. When undefined, responses carry
//                       raw read-first RAM data.
//
// Ports:
//   clka, rstb                 clock; synchronous active-high reset
//   rd0_valid/addr/ready       requester 0 read request handshake
//   rd1_valid/addr/ready       requester 1 read request handshake
//   wr_valid/addr/data         write client (no backpressure)
//   rsp_valid/id/data          read response (no backpressure)
//   ram_addra/dina/wea         RAM write port
//   ram_addrb/enb/regceb/rstb  RAM read port controls
//   ram_doutb                  RAM read data (output register)
module sdp_ram_rd_arbiter #(
  parameter int unsigned RAM_WIDTH = 64,
  parameter int unsigned RAM_DEPTH = 512,
  localparam int unsigned AW = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 rd0_valid,
  input  logic [AW-1:0]        rd0_addr,
  output logic                 rd0_ready,
  input  logic                 rd1_valid,
  input  logic [AW-1:0]        rd1_addr,
  output logic                 rd1_ready,
  input  logic                 wr_valid,
  input  logic [AW-1:0]        wr_addr,
  input  logic [RAM_WIDTH-1:0] wr_data,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [RAM_WIDTH-1:0] rsp_data,
  output logic [AW-1:0]        ram_addra,
  output logic [RAM_WIDTH-1:0] ram_dina,
  output logic                 ram_wea,
  output logic [AW-1:0]        ram_addrb,
  output logic                 ram_enb,
  output logic                 ram_regceb,
  output logic                 ram_rstb,
  input  logic [RAM_WIDTH-1:0] ram_doutb
);

  // Index of the requester granted most recently. Resets to 1 so that
  // requester 0 wins the first contended cycle.
  logic last_q;

  logic gnt0, gnt1, gnt_any, gnt_id;

  // In-flight pipeline: stage 1 = cycle T+1 (RAM output register loading),
  // stage 2 = cycle T+2 (response presented).
  logic s1_valid_q, s1_id_q;
  logic s2_valid_q, s2_id_q;

  // Write port is a straight pass-through.
  assign ram_wea   = wr_valid;
  assign ram_addra = wr_addr;
  assign ram_dina  = wr_data;
  assign ram_rstb  = rstb;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rstb) begin
      gnt0 = rd0_valid & (~rd1_valid | last_q);
      gnt1 = rd1_valid & (~rd0_valid | ~last_q);
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign gnt_id    = gnt1;
  assign rd0_ready = gnt0;
  assign rd1_ready = gnt1;
  assign ram_enb   = gnt_any;
  assign ram_addrb = gnt1 ? rd1_addr : rd0_addr;

  assign ram_regceb = s1_valid_q & ~rstb;

  always_ff @(posedge clka) begin
    if (rstb) begin
      last_q     <= 1'b1;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_id_q    <= 1'b0;
    end else begin
      if (gnt_any) last_q <= gnt_id;
      s1_valid_q <= gnt_any;
      s1_id_q    <= gnt_id;
      s2_valid_q <= s1_valid_q;
      // rsp_id holds its last value between responses.
      if (s1_valid_q) s2_id_q <= s1_id_q;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_id    = s2_id_q;

`ifdef SDP_ARB_WR_FWD_EN
  logic [AW-1:0]        s1_addr_q;
  logic                 s1_hit_q, s2_hit_q;
  logic [RAM_WIDTH-1:0] s1_fwd_q, s2_fwd_q;
  logic                 t0_hit, t1_hit;

  // T: write in the acceptance cycle; T+1: write while the read is in stage 1.
  assign t0_hit = gnt_any & wr_valid & (wr_addr == ram_addrb);
  assign t1_hit = s1_valid_q & wr_valid & (wr_addr == s1_addr_q);

  always_ff @(posedge clka) begin
    if (rstb) begin
      s1_hit_q <= 1'b0;
      s2_hit_q <= 1'b0;
    end else begin
      s1_hit_q <= t0_hit;
      s2_hit_q <= t1_hit | (s1_valid_q & s1_hit_q);
    end
  end

  always_ff @(posedge clka) begin
    s1_addr_q <= ram_addrb;
    s1_fwd_q  <= wr_data;
    // The later (T+1) write takes precedence over the T write.
    s2_fwd_q  <= t1_hit ? wr_data : s1_fwd_q;
  end

  assign rsp_data = (s2_valid_q & s2_hit_q) ? s2_fwd_q : ram_doutb;
`else
  assign rsp_data = ram_doutb;
`endif

endmodule

// File: tb/tb_sdp_ram_rd_arbiter.sv
module tb_sdp_ram_rd_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned D  = 512;
  localparam int unsigned AW = 9;

  logic          clka = 1'b0;
  logic          rstb = 1'b1;
  logic          rd0_valid = 1'b0, rd1_valid = 1'b0, wr_valid = 1'b0;
  logic [AW-1:0] rd0_addr = '0, rd1_addr = '0, wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd0_ready, rd1_ready, rsp_valid, rsp_id;
  logic [W-1:0]  rsp_data;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [W-1:0]  ram_dina, ram_doutb;
  logic          ram_wea, ram_enb, ram_regceb, ram_rstb;

  sdp_ram_rd_arbiter #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clka(clka), .rstb(rstb),
    .rd0_valid(rd0_valid), .rd0_addr(rd0_addr), .rd0_ready(rd0_ready),
    .rd1_valid(rd1_valid), .rd1_addr(rd1_addr), .rd1_ready(rd1_ready),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_regceb(ram_regceb),
    .ram_rstb(ram_rstb), .ram_doutb(ram_doutb)
  );

  always #5 clka = ~clka;

  // Behavioural 2-cycle read-first RAM.
  logic [W-1:0] mem [D];
  logic [W-1:0] lat_q = '0;
  logic [W-1:0] dout_q = '0;
  assign ram_doutb = dout_q;
  initial for (int i = 0; i < int'(D); i++) mem[i] = '0;
  always @(posedge clka) begin
    if (ram_wea) mem[ram_addra] <= ram_dina;
    if (ram_enb) lat_q <= mem[ram_addrb];
    if (ram_rstb) dout_q <= '0;
    else if (ram_regceb) dout_q <= lat_q;
  end

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  typedef struct {
    logic         id;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_fail = 0;
  logic last_id = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input logic id, input logic [W-1:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    e.cyc = cyc + 2;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard whenever a response appears.
  always @(negedge clka) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp at cycle %0d: got id %0d data %h, expected none",
                 cyc, rsp_id, rsp_data);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", {63'd0, rsp_id}, {63'd0, e.id});
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_cycle", W'(cyc), W'(e.cyc));
        last_id = e.id;
      end
    end else if (rstb) begin
      last_id = 1'b0;
    end else begin
      chk("rsp_id_hold", {63'd0, rsp_id}, {63'd0, last_id});
      chk("rsp_data_idle", rsp_data, ram_doutb);
    end
  end

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    step();
    wr_valid = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    repeat (3) step();
    rstb = 1'b1;
    rd0_valid = 1'b1;
    rd1_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      chk("rst_rd0_ready", {63'd0, rd0_ready}, 64'd0);
      chk("rst_rd1_ready", {63'd0, rd1_ready}, 64'd0);
      chk("rst_ram_enb", {63'd0, ram_enb}, 64'd0);
      chk("rst_ram_regceb", {63'd0, ram_regceb}, 64'd0);
      chk("rst_ram_rstb", {63'd0, ram_rstb}, 64'd1);
      step();
    end
    rstb = 1'b0;
    rd0_valid = 1'b0;
    rd1_valid = 1'b0;
  endtask

  logic [W-1:0] exp_fwd7, exp_fwd3;

  initial begin
`ifdef SDP_ARB_WR_FWD_EN
    exp_fwd7 = 64'h22;
    exp_fwd3 = 64'h44;
`else
    exp_fwd7 = 64'h11;
    exp_fwd3 = 64'h01;
`endif
    do_reset();
    @(negedge clka);
    chk("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("post_rst_rsp_id", {63'd0, rsp_id}, 64'd0);

    // Preload, then single read of addr 5.
    wr(9'd10, 64'h1010);
    wr(9'd11, 64'h1111);
    wr(9'd3, 64'h01);
    wr(9'd5, 64'hAA);
    rd0_valid = 1'b1;
    rd0_addr = 9'd5;
    push(1'b0, 64'hAA);
    @(negedge clka);
    chk("rd0_ready_single", {63'd0, rd0_ready}, 64'd1);
    chk("ram_enb_single", {63'd0, ram_enb}, 64'd1);
    chk("ram_addrb_single", {55'd0, ram_addrb}, 64'd5);
    step();
    rd0_valid = 1'b0;
    @(negedge clka);
    chk("ram_regceb_t1", {63'd0, ram_regceb}, 64'd1);
    chk("ram_enb_idle", {63'd0, ram_enb}, 64'd0);

    // Contention for 4 cycles: grants alternate starting at 0.
    do_reset();
    rd0_addr = 9'd10;
    rd1_addr = 9'd11;
    for (int i = 0; i < 4; i++) begin
      step();
      rd0_valid = 1'b1;
      rd1_valid = 1'b1;
      push(i[0], i[0] ? 64'h1111 : 64'h1010);
      @(negedge clka);
      chk("rr_rd0_ready", {63'd0, rd0_ready}, {63'd0, ~i[0]});
      chk("rr_rd1_ready", {63'd0, rd1_ready}, {63'd0, i[0]});
      chk("rr_ram_addrb", {55'd0, ram_addrb}, i[0] ? 64'd11 : 64'd10);
    end
    step();
    rd0_valid = 1'b0;
    rd1_valid = 1'b0;

    // Write at T+1 to the address read at T.
    wr(9'd7, 64'h11);
    rd1_valid = 1'b1;
    rd1_addr = 9'd7;
    push(1'b1, exp_fwd7);
    step();
    rd1_valid = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 9'd7;
    wr_data = 64'h22;
    step();
    wr_valid = 1'b0;

    // Writes at T and T+1 to the address read at T; later write wins.
    step();
    rd0_valid = 1'b1;
    rd0_addr = 9'd3;
    wr_valid = 1'b1;
    wr_addr = 9'd3;
    wr_data = 64'h33;
    push(1'b0, exp_fwd3);
    step();
    rd0_valid = 1'b0;
    wr_data = 64'h44;
    step();
    wr_valid = 1'b0;

    // Reset in the cycle after an accepted read drops the read.
    do_reset();
    step();
    rd0_valid = 1'b1;
    rd0_addr = 9'd5;
    @(negedge clka);
    chk("pre_rst_rd0_ready", {63'd0, rd0_ready}, 64'd1);
    step();
    rstb = 1'b1;
    @(negedge clka);
    chk("mid_rst_rd0_ready", {63'd0, rd0_ready}, 64'd0);
    chk("mid_rst_regceb", {63'd0, ram_regceb}, 64'd0);
    step();
    rstb = 1'b0;
    rd0_valid = 1'b0;
    @(negedge clka);
    chk("dropped_rsp_t2", {63'd0, rsp_valid}, 64'd0);
    step();
    @(negedge clka);
    chk("dropped_rsp_t3", {63'd0, rsp_valid}, 64'd0);
    step();
    rd0_valid = 1'b1;
    rd1_valid = 1'b1;
    rd0_addr = 9'd5;
    rd1_addr = 9'd10;
    push(1'b0, 64'hAA);
    @(negedge clka);
    chk("post_rst_rd0_wins", {63'd0, rd0_ready}, 64'd1);
    chk("post_rst_rd1_loses", {63'd0, rd1_ready}, 64'd0);
    step();
    rd0_valid = 1'b0;
    rd1_valid = 1'b0;
    repeat (2) step();

    // Idle: no read-side activity.
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clka);
      chk("idle_ram_enb", {63'd0, ram_enb}, 64'd0);
      chk("idle_ram_regceb", {63'd0, ram_regceb}, 64'd0);
      chk("idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
